// File: rtl/fft_butterfly_pkg.sv
// fft_butterfly_pkg: shared FFT constants and the 8-point twiddle table.
// Twiddles are W8^k scaled by TW_SCALE and rounded to signed TW_W-bit values.
package fft_butterfly_pkg;
  localparam int TW_W = 8;
  localparam int TW_SCALE = 10;
  localparam int TW_IDX_W = 3;
  typedef struct packed {
    logic signed [TW_W-1:0] re;
    logic signed [TW_W-1:0] im;
  } tw_t;
  function automatic tw_t tw_rom(input logic [TW_IDX_W-1:0] k);
    case (k)
      3'd0: return tw_t'{TW_W'(10), TW_W'(0)};
      3'd1: return tw_t'{TW_W'(7), TW_W'(-7)};
      3'd2: return tw_t'{TW_W'(0), TW_W'(-10)};
      3'd3: return tw_t'{TW_W'(-7), TW_W'(-7)};
      3'd4: return tw_t'{TW_W'(-10), TW_W'(0)};
      3'd5: return tw_t'{TW_W'(-7), TW_W'(7)};
      3'd6: return tw_t'{TW_W'(0), TW_W'(10)};
      default: return tw_t'{TW_W'(7), TW_W'(7)};
    endcase
  endfunction
endpackage

// File: rtl/fft_butterfly_twiddle_lut.sv
// twiddle_lut: combinational lookup of the scaled twiddle factor W8^k.
module twiddle_lut
  import fft_butterfly_pkg::*;
(
  input  logic [TW_IDX_W-1:0]    i_idx,
  output logic signed [TW_W-1:0] o_w_re,
  output logic signed [TW_W-1:0] o_w_im
);
  tw_t w_tw;
  assign w_tw   = tw_rom(i_idx);
  assign o_w_re = w_tw.re;
  assign o_w_im = w_tw.im;
endmodule

// File: rtl/fft_butterfly.sv
// fft_butterfly: 3-stage radix-2 DIT butterfly x = a+W*b, y = a-W*b with ready/valid flow control.
// Define FFT_BUTTERFLY_SAT_EN to saturate x and y to the signed DATA_W range.
module fft_butterfly
  import fft_butterfly_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic signed [DATA_W-1:0] i_a_re,
  input  logic signed [DATA_W-1:0] i_a_im,
  input  logic signed [DATA_W-1:0] i_b_re,
  input  logic signed [DATA_W-1:0] i_b_im,
  input  logic [TW_IDX_W-1:0]      i_tw_idx,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic signed [DATA_W+1:0] o_x_re,
  output logic signed [DATA_W+1:0] o_x_im,
  output logic signed [DATA_W+1:0] o_y_re,
  output logic signed [DATA_W+1:0] o_y_im,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_busy
);
  localparam int P_W = DATA_W + TW_W + 1;
  localparam int O_W = DATA_W + 2;
  localparam logic signed [P_W-1:0] L_SCALE = P_W'(TW_SCALE);
  logic w_adv;
  logic signed [TW_W-1:0] w_tw_re, w_tw_im;
  logic r1_valid, r2_valid, r3_valid;
  logic signed [DATA_W-1:0] r1_a_re, r1_a_im, r1_b_re, r1_b_im;
  logic signed [TW_W-1:0] r1_w_re, r1_w_im;
  logic signed [DATA_W-1:0] r2_a_re, r2_a_im;
  logic signed [P_W-1:0] w_br, w_bi, w_wr, w_wi, w_p_re, w_p_im, r2_p_re, r2_p_im;
  logic signed [O_W-1:0] w_q_re, w_q_im, w_a_re, w_a_im;
  logic signed [O_W-1:0] w_x_re, w_x_im, w_y_re, w_y_im;
  logic signed [O_W-1:0] w_xo_re, w_xo_im, w_yo_re, w_yo_im;
  logic signed [O_W-1:0] r3_x_re, r3_x_im, r3_y_re, r3_y_im;
  // The whole pipeline moves as one unit whenever the output slot is free or being drained.
  assign w_adv   = !r3_valid | i_ready;
  assign o_ready = w_adv;
  assign o_valid = r3_valid;
  assign o_busy  = r1_valid | r2_valid | r3_valid;
  assign o_x_re  = r3_x_re;
  assign o_x_im  = r3_x_im;
  assign o_y_re  = r3_y_re;
  assign o_y_im  = r3_y_im;
  twiddle_lut u_twiddle_lut (
    .i_idx (i_tw_idx),
    .o_w_re(w_tw_re),
    .o_w_im(w_tw_im)
  );
  assign w_br   = P_W'(r1_b_re);
  assign w_bi   = P_W'(r1_b_im);
  assign w_wr   = P_W'(r1_w_re);
  assign w_wi   = P_W'(r1_w_im);
  assign w_p_re = w_br * w_wr - w_bi * w_wi;
  assign w_p_im = w_br * w_wi + w_bi * w_wr;
  // Signed division truncates toward zero; the quotient always fits in O_W bits.
  assign w_q_re = O_W'(r2_p_re / L_SCALE);
  assign w_q_im = O_W'(r2_p_im / L_SCALE);
  assign w_a_re = O_W'(r2_a_re);
  assign w_a_im = O_W'(r2_a_im);
  assign w_x_re = w_a_re + w_q_re;
  assign w_x_im = w_a_im + w_q_im;
  assign w_y_re = w_a_re - w_q_re;
  assign w_y_im = w_a_im - w_q_im;
`ifdef FFT_BUTTERFLY_SAT_EN
  localparam logic signed [O_W-1:0] SAT_MAX = O_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [O_W-1:0] SAT_MIN = O_W'(-(1 << (DATA_W - 1)));
  function automatic logic signed [O_W-1:0] sat(input logic signed [O_W-1:0] v);
    return (v > SAT_MAX) ? SAT_MAX : (v < SAT_MIN) ? SAT_MIN : v;
  endfunction
  assign w_xo_re = sat(w_x_re);
  assign w_xo_im = sat(w_x_im);
  assign w_yo_re = sat(w_y_re);
  assign w_yo_im = sat(w_y_im);
`else
  assign w_xo_re = w_x_re;
  assign w_xo_im = w_x_im;
  assign w_yo_re = w_y_re;
  assign w_yo_im = w_y_im;
`endif
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r1_valid <= 1'b0;
      r1_a_re  <= '0;
      r1_a_im  <= '0;
      r1_b_re  <= '0;
      r1_b_im  <= '0;
      r1_w_re  <= '0;
      r1_w_im  <= '0;
      r2_valid <= 1'b0;
      r2_a_re  <= '0;
      r2_a_im  <= '0;
      r2_p_re  <= '0;
      r2_p_im  <= '0;
      r3_valid <= 1'b0;
      r3_x_re  <= '0;
      r3_x_im  <= '0;
      r3_y_re  <= '0;
      r3_y_im  <= '0;
    end else if (w_adv) begin
      r1_valid <= i_valid;
      r1_a_re  <= i_a_re;
      r1_a_im  <= i_a_im;
      r1_b_re  <= i_b_re;
      r1_b_im  <= i_b_im;
      r1_w_re  <= w_tw_re;
      r1_w_im  <= w_tw_im;
      r2_valid <= r1_valid;
      r2_a_re  <= r1_a_re;
      r2_a_im  <= r1_a_im;
      r2_p_re  <= w_p_re;
      r2_p_im  <= w_p_im;
      r3_valid <= r2_valid;
      r3_x_re  <= w_xo_re;
      r3_x_im  <= w_xo_im;
      r3_y_re  <= w_yo_re;
      r3_y_im  <= w_yo_im;
    end
  end
endmodule

// File: doc/fft_butterfly.md
FFT_BUTTERFLY -- requirements
Module: fft_butterfly

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the signed width of each input real/imag component.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports i_a_re, i_a_im  input  DATA_W  signed upper operand a.
REQ-005 SHALL have ports i_b_re, i_b_im  input  DATA_W  signed lower operand b.
REQ-006 SHALL have port i_tw_idx  input  3  twiddle index k for W8^k.
REQ-007 SHALL have port i_valid  input  1  the input operand set is valid.
REQ-008 SHALL have port o_ready  output  1  the block accepts the input operand set this cycle.
REQ-009 SHALL have ports o_x_re, o_x_im, o_y_re, o_y_im  output  DATA_W+2  signed results x = a+W*b and y = a-W*b.
REQ-010 SHALL have port o_valid  output  1  the results are valid.
REQ-011 SHALL have port i_ready  input  1  downstream accepts the results.
REQ-012 SHALL have port o_busy  output  1  high while any pipeline stage holds valid data.

Function
REQ-013 SHALL obtain the twiddle factor W as signed 8-bit values scaled by 10: k=0 (10,0), 1 (7,-7), 2 (0,-10), 3 (-7,-7), 4 (-10,0), 5 (-7,7), 6 (0,10), 7 (7,7).
REQ-014 SHALL compute the full-precision products p_re = b_re*w_re - b_im*w_im and p_im = b_re*w_im + b_im*w_re.
REQ-015 SHALL descale each product by signed division by 10, truncating toward zero, so that q = p/10.
REQ-016 SHALL compute x = a+q and y = a-q exactly at DATA_W+2 bits with no wrap, since |q| <= 179 for DATA_W=8.
REQ-017 SHALL be a 3-stage pipeline: S1 registers the operands and the looked-up twiddle, S2 registers p, S3 registers x and y.
REQ-018 SHALL define advance = !o_valid | i_ready, with o_ready = advance.
REQ-019 SHALL shift all stages, together with their valid bits, only when advance is high, and SHALL hold all stages when advance is low.
REQ-020 SHALL have a latency of 3 cycles from an accepted input (i_valid & o_ready) to o_valid when there is no stall, with a throughput of 1 per cycle.
REQ-021 SHALL hold o_x_*, o_y_* and o_valid stable while o_valid & !i_ready.
REQ-022 SHALL deliver results in acceptance order, with no loss and no duplication.
REQ-023 SHALL transfer the input and the output in the same cycle when i_valid, o_valid and i_ready are all high.
REQ-024 SHALL treat i_valid low while o_ready is high as a bubble that propagates through the pipeline.

Reset
REQ-025 SHALL on i_rst asynchronously clear all valid bits, o_valid and o_busy, and set all data outputs to 0.
REQ-026 SHALL discard in-flight data on a reset asserted mid-operation; no stale result SHALL appear after release.
REQ-027 SHALL accept input from the first rising i_clk edge after release, with o_ready = 1.

Configuration
REQ-028 SHALL with macro FFT_BUTTERFLY_SAT_EN defined saturate x and y to the signed DATA_W range [-2^(DATA_W-1), 2^(DATA_W-1)-1] in S3, sign-extended onto the DATA_W+2 ports.
REQ-029 SHALL without FFT_BUTTERFLY_SAT_EN output the exact unsaturated values of REQ-016.
REQ-030 SHALL keep the latency and the handshake identical in both builds.

Structure
REQ-031 SHALL take the twiddle constant width (8), the scale factor (10) and the twiddle index width (3) from the shared FFT package.
REQ-032 SHALL instantiate the existing twiddle_lut as its sole sub-module, indexed by i_tw_idx in S1.

Verification
REQ-033 SHALL cover: k=0, a=(5,3), b=(2,-1) -> x=(7,2), y=(3,4), with o_valid exactly 3 cycles after acceptance.
REQ-034 SHALL cover: k=2, a=(1,1), b=(4,6) -> x=(7,-3), y=(-5,5).
REQ-035 SHALL cover truncation: k=1, a=(0,0), b=(3,0) -> p=(21,-21) -> x=(2,-2), y=(-2,2).
REQ-036 SHALL cover the extreme case: k=1, a=(-128,0), b=(-128,-128) -> x_re=-307, y_re=51 without the macro; x_re=-128, y_re=51 with FFT_BUTTERFLY_SAT_EN.
REQ-037 SHALL cover backpressure: 4 back-to-back inputs with i_ready low on cycles 2-3 -> 4 results in order, outputs stable while stalled, o_ready low during the stall.
REQ-038 SHALL cover reset mid-operation: i_rst pulsed with 2 operand sets in flight -> o_valid and o_busy 0 immediately, and no result emitted after release.
